// File: rtl/simd_fetch_unit.sv
// Instruction fetch stage: streams words from a synchronous instruction memory into a
// 2-entry FIFO and presents them to the SIMD decoder until the RET word is consumed.
module simd_fetch_unit #(
    parameter int unsigned PC_WIDTH = 9,
    parameter logic [31:0] RET_WORD = 32'hD65F03C0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_pc,
    input  logic                flush,
    output logic                imem_rd_en,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic                busy,
    output logic                done
);
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [31:0]         fifo_word [DEPTH];
    logic [PC_WIDTH-1:0] fifo_pc   [DEPTH];
    logic                wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                inflight;
    logic [PC_WIDTH-1:0] pc, inflight_pc;
    logic                pop, push, done_nxt;
    logic [OCC_W-1:0]    occupancy;

    assign instr_valid = (count != '0);
    assign instr_out   = fifo_word[rd_ptr];
    assign pc_out      = fifo_pc[rd_ptr];
    assign imem_addr   = pc;
    assign busy        = (state != IDLE);

    // Next state, read issue and FIFO push/pop decisions; flush overrides everything.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        done_nxt   = 1'b0;
        imem_rd_en = 1'b0;
        pop        = instr_valid & instr_ready;
        occupancy  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                imem_rd_en = (occupancy < OCC_W'(DEPTH));
                push       = inflight;
                if (inflight && imem_rdata == RET_WORD) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Nothing is pushed in DRAIN, so the last remaining entry is the RET word.
                if (pop && count == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt  = IDLE;
            push       = 1'b0;
            done_nxt   = 1'b0;
            imem_rd_en = 1'b0;
        end
    end

    // State, FIFO storage, PC and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            count       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            inflight    <= 1'b0;
            pc          <= '0;
            inflight_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (flush) begin
                count    <= '0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                inflight <= 1'b0;
            end else begin
                if (push) begin
                    fifo_word[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]   <= inflight_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count    <= count + CNT_W'(push) - CNT_W'(pop);
                inflight <= imem_rd_en;
                if (imem_rd_en) begin
                    inflight_pc <= pc;
                    pc          <= pc + PC_WIDTH'(1);
                end
                if (state == IDLE && start) pc <= start_pc;
            end
        end
    end
endmodule
